// File: rtl/shift_register_univ.sv
// shift_register_univ: WIDTH-bit universal shift register with hold, shift right/left,
// parallel load, synchronous clear, a shift counter and a registered Done pulse.
// Optional rotate modes are compiled in when SHIFT_REGISTER_ROTATE_EN is defined;
// otherwise modes 100/101 act as hold and no rotate logic is built.
module shift_register_univ #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CW    = $clog2(WIDTH + 1)
) (
  input  logic             Ck,
  input  logic             Reset,
  input  logic [2:0]       Mode,
  input  logic             SIR,
  input  logic             SIL,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             SOR,
  output logic             SOL,
  output logic [CW-1:0]    Count,
  output logic             Done
);

  localparam logic [2:0] ModeHold  = 3'b000;
  localparam logic [2:0] ModeShr   = 3'b001;
  localparam logic [2:0] ModeShl   = 3'b010;
  localparam logic [2:0] ModeLoad  = 3'b011;
  localparam logic [2:0] ModeRotR  = 3'b100;
  localparam logic [2:0] ModeRotL  = 3'b101;
  localparam logic [2:0] ModeClear = 3'b110;

  localparam logic [CW-1:0] CountLast = CW'(WIDTH - 1);

  logic [WIDTH-1:0] q_q, q_d;
  logic [CW-1:0]    count_q, count_d;
  logic             done_q, done_d;
  logic             cnt_inc;
  logic             cnt_clr;
  logic             cnt_wrap;

  // Decode the operation into the next register value and counter action.
  always_comb begin
    q_d     = q_q;
    cnt_inc = 1'b0;
    cnt_clr = 1'b0;
    case (Mode)
      ModeHold: ;
      ModeShr: begin
        q_d     = {SIR, q_q[WIDTH-1:1]};
        cnt_inc = 1'b1;
      end
      ModeShl: begin
        q_d     = {q_q[WIDTH-2:0], SIL};
        cnt_inc = 1'b1;
      end
      ModeLoad: begin
        q_d     = D;
        cnt_clr = 1'b1;
      end
`ifdef SHIFT_REGISTER_ROTATE_EN
      ModeRotR: begin
        q_d     = {q_q[0], q_q[WIDTH-1:1]};
        cnt_inc = 1'b1;
      end
      ModeRotL: begin
        q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        cnt_inc = 1'b1;
      end
`else
      ModeRotR, ModeRotL: ;
`endif
      ModeClear: begin
        q_d     = '0;
        cnt_clr = 1'b1;
      end
      default: ;  // 111 is reserved and holds
    endcase
  end

  // Counter wraps after WIDTH shifts; Done flags exactly that wrap.
  always_comb begin
    cnt_wrap = (count_q == CountLast);
    count_d  = count_q;
    done_d   = 1'b0;
    if (cnt_clr) begin
      count_d = '0;
    end else if (cnt_inc) begin
      count_d = cnt_wrap ? '0 : count_q + CW'(1);
      done_d  = cnt_wrap;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge Ck or negedge Reset) begin
    if (!Reset) begin
      q_q     <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign Q     = q_q;
  assign SOR   = q_q[0];
  assign SOL   = q_q[WIDTH-1];
  assign Count = count_q;
  assign Done  = done_q;

endmodule
